// File: rtl/program_mem_arbiter_if.sv
// rtl/program_mem_arbiter_if.sv - Fetcher-side and program-memory read channel bundle
// slave is the arbiter's view; master is the surrounding fetchers and memory.
interface program_mem_arbiter_if #(
   parameter int NUM_CONSUMERS = 4,
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16
);
   localparam int GRANT_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
   logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
   logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
   logic                               mem_read_valid;
   logic [ADDR_BITS-1:0]               mem_read_address;
   logic                               mem_read_ready;
   logic [DATA_BITS-1:0]               mem_read_data;
   logic [GRANT_BITS-1:0]              grant_id;
   logic                               busy;

   modport slave (
      input  consumer_read_valid,
      input  consumer_read_address,
      input  mem_read_ready,
      input  mem_read_data,
      output consumer_read_ready,
      output consumer_read_data,
      output mem_read_valid,
      output mem_read_address,
      output grant_id,
      output busy
   );

   modport master (
      output consumer_read_valid,
      output consumer_read_address,
      output mem_read_ready,
      output mem_read_data,
      input  consumer_read_ready,
      input  consumer_read_data,
      input  mem_read_valid,
      input  mem_read_address,
      input  grant_id,
      input  busy
   );
endinterface

// File: rtl/program_mem_arbiter.sv
// rtl/program_mem_arbiter.sv - Round-robin arbiter sharing one program-memory read channel
// One read outstanding at a time; grant rotates from the last served fetcher.
module program_mem_arbiter #(
   parameter int NUM_CONSUMERS = 4,
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   program_mem_arbiter_if.slave  bus
);
   localparam int GB = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_WAIT_MEM = 2'b01,
      ST_RELAY    = 2'b10
   } state_t;

   state_t                     r_state;
   logic [GB-1:0]              r_last_grant;
   logic [GB-1:0]              r_grant;
   logic                       r_mem_valid;
   logic [ADDR_BITS-1:0]       r_mem_addr;
   logic [NUM_CONSUMERS-1:0]   r_cons_ready;
   logic                       r_busy;
   logic [DATA_BITS-1:0]       r_data [NUM_CONSUMERS];

   logic [ADDR_BITS-1:0]       w_addr [NUM_CONSUMERS];
   logic                       w_hit;
   logic [GB-1:0]              w_pick;
   logic [GB-1:0]              w_cand;

   always_comb begin
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
         w_addr[i] = bus.consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
      end
   end

   // Scan from farthest to nearest so the last hit written is the one closest after r_last_grant.
   always_comb begin
      w_hit  = 1'b0;
      w_pick = '0;
      w_cand = '0;
      for (int k = NUM_CONSUMERS; k >= 1; k--) begin
         w_cand = GB'((int'(r_last_grant) + k) % NUM_CONSUMERS);
         if (bus.consumer_read_valid[w_cand]) begin
            w_hit  = 1'b1;
            w_pick = w_cand;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= GB'(NUM_CONSUMERS - 1);
         r_grant      <= '0;
         r_mem_valid  <= 1'b0;
         r_mem_addr   <= '0;
         r_cons_ready <= '0;
         r_busy       <= 1'b0;
         for (int i = 0; i < NUM_CONSUMERS; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hit) begin
                  r_grant     <= w_pick;
                  r_mem_addr  <= w_addr[w_pick];
                  r_mem_valid <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= ST_WAIT_MEM;
               end
            end
            ST_WAIT_MEM: begin
               if (bus.mem_read_ready) begin
                  r_data[r_grant]       <= bus.mem_read_data;
                  r_cons_ready[r_grant] <= 1'b1;
                  r_mem_valid           <= 1'b0;
                  r_state               <= ST_RELAY;
               end
            end
            ST_RELAY: begin
               if (!bus.consumer_read_valid[r_grant]) begin
                  r_cons_ready <= '0;
                  r_last_grant <= r_grant;
                  r_busy       <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_cons_ready <= '0;
               r_mem_valid  <= 1'b0;
               r_busy       <= 1'b0;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_data
         assign bus.consumer_read_data[gi*DATA_BITS +: DATA_BITS] = r_data[gi];
      end
   endgenerate

   assign bus.consumer_read_ready = r_cons_ready;
   assign bus.mem_read_valid      = r_mem_valid;
   assign bus.mem_read_address    = r_mem_addr;
   assign bus.grant_id            = r_grant;
   assign bus.busy                = r_busy;
endmodule

// File: tb/tb_program_mem_arbiter.sv
// tb/tb_program_mem_arbiter.sv - Directed scoreboard bench for program_mem_arbiter
module tb_program_mem_arbiter;
   localparam int N  = 4;
   localparam int AB = 8;
   localparam int DB = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   program_mem_arbiter_if #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) bus();

   program_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          cons;
      logic [7:0]  addr;
      logic [15:0] data;
   } exp_t;

   exp_t            sb[$];
   logic [N*DB-1:0] exp_data;
   int              n_checks = 0;
   int              n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic request(input int c, input logic [7:0] a, input logic [15:0] d);
      bus.consumer_read_address[c*AB +: AB] = a;
      bus.consumer_read_valid[c] = 1'b1;
      sb.push_back('{c, a, d});
   endtask

   task automatic wait_grant(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bus.mem_read_valid;
      end
   endtask

   task automatic txn(input int stall, input bit drop_early, input bit bump_addr, input bit rerequest);
      exp_t e;
      bit   seen;
      wait_grant(seen);
      chk("grant_seen", 64'(seen), 64'd1);
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (!seen || sb.size() == 0) return;
      e = sb.pop_front();
      chk("grant_id", 64'(bus.grant_id), 64'(e.cons));
      chk("mem_addr", 64'(bus.mem_read_address), 64'(e.addr));
      chk("busy_wait", 64'(bus.busy), 64'd1);
      if (bump_addr) bus.consumer_read_address[e.cons*AB +: AB] = e.addr + 8'd1;
      for (int s = 0; s < stall; s++) begin
         bus.mem_read_ready = 1'b0;
         @(negedge clk);
         chk("stall_valid", 64'(bus.mem_read_valid), 64'd1);
         chk("stall_addr", 64'(bus.mem_read_address), 64'(e.addr));
         chk("stall_ready", 64'(bus.consumer_read_ready), 64'd0);
         chk("stall_busy", 64'(bus.busy), 64'd1);
      end
      bus.mem_read_ready = 1'b1;
      bus.mem_read_data  = e.data;
      if (drop_early) bus.consumer_read_valid[e.cons] = 1'b0;
      @(negedge clk);
      bus.mem_read_ready = 1'b0;
      bus.mem_read_data  = '0;
      exp_data[e.cons*DB +: DB] = e.data;
      chk("ready_onehot", 64'(bus.consumer_read_ready), 64'(4'b0001 << e.cons));
      chk("data_vec", 64'(bus.consumer_read_data), 64'(exp_data));
      chk("mem_valid_drop", 64'(bus.mem_read_valid), 64'd0);
      bus.consumer_read_valid[e.cons] = 1'b0;
      @(negedge clk);
      chk("ready_clear", 64'(bus.consumer_read_ready), 64'd0);
      chk("busy_idle", 64'(bus.busy), 64'd0);
      if (rerequest) bus.consumer_read_valid[e.cons] = 1'b1;
   endtask

   initial begin
      bit seen;
      bus.consumer_read_valid   = '0;
      bus.consumer_read_address = '0;
      bus.mem_read_ready        = 1'b0;
      bus.mem_read_data         = '0;
      exp_data                  = '0;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(bus.consumer_read_ready), 64'd0);
      chk("rst_data", 64'(bus.consumer_read_data), 64'd0);
      chk("rst_mem_valid", 64'(bus.mem_read_valid), 64'd0);
      chk("rst_mem_addr", 64'(bus.mem_read_address), 64'd0);
      chk("rst_grant", 64'(bus.grant_id), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // memory ready while idle is ignored
      bus.mem_read_ready = 1'b1;
      bus.mem_read_data  = 16'hFFFF;
      @(negedge clk);
      bus.mem_read_ready = 1'b0;
      bus.mem_read_data  = '0;
      chk("stray_ready", 64'(bus.consumer_read_ready), 64'd0);
      chk("stray_data", 64'(bus.consumer_read_data), 64'(exp_data));
      chk("stray_busy", 64'(bus.busy), 64'd0);

      // single request from consumer 2
      request(2, 8'h0A, 16'hABCD);
      txn(0, 1'b0, 1'b0, 1'b0);

      // memory stall of 5 cycles
      request(2, 8'h33, 16'h5555);
      txn(5, 1'b0, 1'b0, 1'b0);

      // reset during WAIT_MEM
      bus.consumer_read_address[0 +: AB] = 8'h44;
      bus.consumer_read_valid[0] = 1'b1;
      wait_grant(seen);
      chk("rst_test_grant_seen", 64'(seen), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("async_mem_valid", 64'(bus.mem_read_valid), 64'd0);
      chk("async_busy", 64'(bus.busy), 64'd0);
      chk("async_ready", 64'(bus.consumer_read_ready), 64'd0);
      bus.consumer_read_valid = '0;
      exp_data = '0;
      @(negedge clk);
      chk("rst_hold_ready", 64'(bus.consumer_read_ready), 64'd0);
      chk("rst_hold_data", 64'(bus.consumer_read_data), 64'd0);
      request(1, 8'h11, 16'h2111);
      request(3, 8'h13, 16'h2313);
      reset = 1'b1;
      txn(0, 1'b0, 1'b0, 1'b0);
      txn(0, 1'b0, 1'b0, 1'b0);

      // all consumers requesting continuously
      request(0, 8'd10, 16'h1000 + 16'd10);
      request(1, 8'd20, 16'h1000 + 16'd20);
      request(2, 8'd30, 16'h1000 + 16'd30);
      request(3, 8'd40, 16'h1000 + 16'd40);
      sb.push_back('{0, 8'd10, 16'h1000 + 16'd10});
      for (int i = 0; i < 4; i++) txn(0, 1'b0, 1'b0, 1'b1);
      txn(0, 1'b0, 1'b0, 1'b0);
      bus.consumer_read_valid = '0;
      chk("cons3_word", 64'(bus.consumer_read_data[3*DB +: DB]), 64'h1028);

      // consumer 1 drops valid during WAIT_MEM
      request(1, 8'h21, 16'h7777);
      txn(0, 1'b1, 1'b0, 1'b0);

      // address change after grant is ignored
      request(2, 8'h05, 16'h0505);
      txn(2, 1'b0, 1'b1, 1'b0);
      bus.consumer_read_valid = '0;

      chk("sb_drained", 64'(sb.size()), 64'd0);
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
